// File: rtl/lfsr_symbol_modulator.sv
// lfsr_symbol_modulator
// Paces an upstream LFSR with a programmable symbol tick, holds one LFSR bit
// per symbol, and uses it to modulate DDS carrier samples.
// The modes are ASK, FSK, BPSK and a raw square wave.
// All outputs are registered.
module lfsr_symbol_modulator #(
  parameter int SAMPLE_W = 12,
  parameter int DIV_W    = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DIV_W-1:0]           symbol_div,
  input  logic [1:0]                 mode,
  input  logic                       lfsr_bit,
  input  logic signed [SAMPLE_W-1:0] carrier_a,
  input  logic signed [SAMPLE_W-1:0] carrier_b,
  input  logic                       carrier_valid,
  output logic                       symbol_tick,
  output logic                       symbol_bit,
  output logic [4:0]                 symbol_count,
  output logic signed [SAMPLE_W-1:0] mod_sample,
  output logic                       mod_valid
);

  typedef enum logic [1:0] {
    MODE_ASK    = 2'b00,
    MODE_FSK    = 2'b01,
    MODE_BPSK   = 2'b10,
    MODE_SQUARE = 2'b11
  } mode_t;

  localparam logic signed [SAMPLE_W-1:0] SAMPLE_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [SAMPLE_W-1:0] SAMPLE_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};
  localparam logic [4:0]                 LAST_SYMBOL = 5'd30;

  logic [DIV_W-1:0]           cnt;
  mode_t                      mode_q;
  logic                       symbol_end;
  logic signed [SAMPLE_W-1:0] sample_p0;
  logic signed [SAMPLE_W-1:0] sample_p1;
  logic                       vld_p1;

  // Two's-complement negation that maps the most negative code to the most
  // positive one instead of wrapping back onto itself.
  function automatic logic signed [SAMPLE_W-1:0] sat_negate(
    input logic signed [SAMPLE_W-1:0] x
  );
    if (x == SAMPLE_MIN) begin
      return SAMPLE_MAX;
    end
    return -x;
  endfunction

  // Maps the held symbol bit and the latched mode onto one output sample.
  function automatic logic signed [SAMPLE_W-1:0] modulate(
    input logic                       b,
    input mode_t                      m,
    input logic signed [SAMPLE_W-1:0] a,
    input logic signed [SAMPLE_W-1:0] f1
  );
    logic signed [SAMPLE_W-1:0] r;
    case (m)
      MODE_ASK:  r = b ? a : '0;
      MODE_FSK:  r = b ? f1 : a;
      MODE_BPSK: r = b ? a : sat_negate(a);
      default:   r = b ? SAMPLE_MAX : SAMPLE_MIN;
    endcase
    return r;
  endfunction

  // The >= compare forces an immediate tick when symbol_div is lowered below
  // the running count, so there is never a wrap through the full counter.
  assign symbol_end = (cnt >= symbol_div);

  // Symbol timer: tick, capture the LFSR bit and latch the mode at each boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt          <= '0;
      symbol_tick  <= 1'b0;
      symbol_bit   <= 1'b0;
      mode_q       <= MODE_ASK;
      symbol_count <= '0;
    end else if (symbol_end) begin
      cnt          <= '0;
      symbol_tick  <= 1'b1;
      symbol_bit   <= lfsr_bit;
      mode_q       <= mode_t'(mode);
      symbol_count <= (symbol_count == LAST_SYMBOL) ? 5'd0 : symbol_count + 5'd1;
    end else begin
      cnt          <= cnt + 1'b1;
      symbol_tick  <= 1'b0;
    end
  end

  // Stage p0: combinational modulation using the currently held symbol.
  assign sample_p0 = modulate(symbol_bit, mode_q, carrier_a, carrier_b);

  // Stage p1: register the modulated sample; hold it while no carrier arrives.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1    <= 1'b0;
      sample_p1 <= '0;
    end else begin
      vld_p1 <= carrier_valid;
      if (carrier_valid) begin
        sample_p1 <= sample_p0;
      end
    end
  end

  assign mod_sample = sample_p1;
  assign mod_valid  = vld_p1;

endmodule

// File: tb/tb_lfsr_symbol_modulator.sv
// Testbench for lfsr_symbol_modulator: table of modulation vectors, hand-written
// timing sequences, and randomized runs checked against a cycle-indexed model.
module tb_lfsr_symbol_modulator;

  localparam int SW    = 12;
  localparam int DW    = 32;
  localparam int SMAX  = (1 << (SW - 1)) - 1;
  localparam int SMIN  = -(1 << (SW - 1));
  localparam int NRAND = 200;

  logic                 clk;
  logic                 reset;
  logic [DW-1:0]        symbol_div;
  logic [1:0]           mode;
  logic                 lfsr_bit;
  logic signed [SW-1:0] carrier_a;
  logic signed [SW-1:0] carrier_b;
  logic                 carrier_valid;
  logic                 symbol_tick;
  logic                 symbol_bit;
  logic [4:0]           symbol_count;
  logic signed [SW-1:0] mod_sample;
  logic                 mod_valid;

  logic                 use_lfsr;
  logic                 bit_drv;
  logic [4:0]           lfsr_q;

  int checks = 0;
  int errors = 0;

  // Per-cycle input history for the randomized model.
  int hb [NRAND];
  int hm [NRAND];
  int ha [NRAND];
  int hf [NRAND];
  int hv [NRAND];
  int run_div;

  lfsr_symbol_modulator #(.SAMPLE_W(SW), .DIV_W(DW)) dut (
    .clk           (clk),
    .reset         (reset),
    .symbol_div    (symbol_div),
    .mode          (mode),
    .lfsr_bit      (lfsr_bit),
    .carrier_a     (carrier_a),
    .carrier_b     (carrier_b),
    .carrier_valid (carrier_valid),
    .symbol_tick   (symbol_tick),
    .symbol_bit    (symbol_bit),
    .symbol_count  (symbol_count),
    .mod_sample    (mod_sample),
    .mod_valid     (mod_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upstream 5-bit LFSR (x^5 + x^2 + 1), advanced by symbol_tick.
  always @(posedge clk) begin
    if (reset) lfsr_q <= 5'b00001;
    else if (symbol_tick) lfsr_q <= {lfsr_q[3:0], lfsr_q[4] ^ lfsr_q[2]};
  end

  assign lfsr_bit = use_lfsr ? lfsr_q[0] : bit_drv;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic signed [SW-1:0] to_s(input int x);
    return x[SW-1:0];
  endfunction

  // Behavioural modulation rules on plain integers.
  function automatic int model_mod(input int b, input int m, input int a, input int f1);
    case (m)
      0:       return b ? a : 0;
      1:       return b ? f1 : a;
      2:       return b ? a : ((a == SMIN) ? SMAX : -a);
      default: return b ? SMAX : SMIN;
    endcase
  endfunction

  // Ticks fall on cycles that are positive multiples of (div+1); the held bit
  // and mode are whatever was presented in the cycle before the latest tick.
  function automatic int held_bit(input int c);
    int n;
    n = c / (run_div + 1);
    return (n == 0) ? 0 : hb[n * (run_div + 1) - 1];
  endfunction

  function automatic int held_mode(input int c);
    int n;
    n = c / (run_div + 1);
    return (n == 0) ? 0 : hm[n * (run_div + 1) - 1];
  endfunction

  typedef struct {
    logic [1:0] m;
    logic       b;
    int         a;
    int         f1;
    int         exp;
  } vec_t;

  vec_t vecs [10];
  int   seq [31];

  initial begin
    logic [4:0] s;
    int ones, held, exp_s, exp_v;
    int pat [4];
    int vals [4];

    reset = 1'b1; symbol_div = '0; mode = 2'b00; bit_drv = 1'b0; use_lfsr = 1'b0;
    carrier_a = '0; carrier_b = '0; carrier_valid = 1'b0;

    vecs[0] = '{2'b00, 1'b1, 256, 80, 256};
    vecs[1] = '{2'b00, 1'b0, 256, 80, 0};
    vecs[2] = '{2'b01, 1'b1, 256, 80, 80};
    vecs[3] = '{2'b01, 1'b0, 256, 80, 256};
    vecs[4] = '{2'b10, 1'b1, 256, 80, 256};
    vecs[5] = '{2'b10, 1'b0, 256, 80, -256};
    vecs[6] = '{2'b11, 1'b1, 256, 80, SMAX};
    vecs[7] = '{2'b11, 1'b0, 256, 80, SMIN};
    vecs[8] = '{2'b10, 1'b0, SMIN, 80, SMAX};
    vecs[9] = '{2'b10, 1'b1, SMIN, 80, SMIN};

    s = 5'b00001;
    for (int k = 0; k < 31; k++) begin
      seq[k] = int'(s[0]);
      s = {s[3:0], s[4] ^ s[2]};
    end

    // Divider and capture with the real LFSR, plus reset state.
    symbol_div = 4; use_lfsr = 1'b1;
    do_reset();
    chk("reset_tick", symbol_tick, 0);
    chk("reset_bit", symbol_bit, 0);
    chk("reset_count", symbol_count, 0);
    chk("reset_sample", mod_sample, 0);
    chk("reset_valid", mod_valid, 0);
    ones = 0;
    for (int c = 0; c <= 165; c++) begin
      chk("div_tick", symbol_tick, (c > 0 && c % 5 == 0) ? 1 : 0);
      if (c > 0 && c % 5 == 0) begin
        chk("div_bit", symbol_bit, seq[(c / 5 - 1) % 31]);
        chk("div_count", symbol_count, (c / 5) % 31);
        if (c <= 155) ones += int'(symbol_bit);
      end
      step();
    end
    chk("mseq_ones", ones, 16);
    use_lfsr = 1'b0;

    // Mode table, one tick per cycle so every bit is captured immediately.
    symbol_div = 0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      mode = vecs[i].m; bit_drv = vecs[i].b;
      carrier_a = to_s(vecs[i].a); carrier_b = to_s(vecs[i].f1); carrier_valid = 1'b1;
      step();
      step();
      chk("mode_vec", mod_sample, vecs[i].exp);
    end

    // Handshake and hold: FSK, bit 1, so mod_sample tracks carrier_b.
    mode = 2'b01; bit_drv = 1'b1; carrier_a = to_s(170); carrier_b = to_s(291);
    carrier_valid = 1'b1;
    step(); step();
    pat  = '{1, 0, 0, 1};
    vals = '{341, 682, 819, 240};
    held = 291;
    for (int i = 0; i < 4; i++) begin
      carrier_valid = pat[i][0]; carrier_b = to_s(vals[i]);
      step();
      if (pat[i] != 0) held = vals[i];
      chk("hs_valid", mod_valid, pat[i]);
      chk("hs_hold", mod_sample, held);
    end
    carrier_valid = 1'b0;

    // symbol_div = 0: continuous tick, new bit every cycle.
    symbol_div = 0;
    do_reset();
    chk("div0_first", symbol_tick, 0);
    for (int i = 0; i < 8; i++) begin
      bit_drv = i[0];
      step();
      chk("div0_tick", symbol_tick, 1);
      chk("div0_bit", symbol_bit, i % 2);
    end

    // Divider lowered mid-symbol from 100 to 3 at cnt = 50.
    symbol_div = 100;
    do_reset();
    for (int c = 0; c < 50; c++) begin
      chk("drop_pre", symbol_tick, 0);
      step();
    end
    chk("drop_at50", symbol_tick, 0);
    symbol_div = 3;
    step();
    chk("drop_force", symbol_tick, 1);
    for (int c = 52; c <= 59; c++) begin
      step();
      chk("drop_period", symbol_tick, ((c - 51) % 4 == 0) ? 1 : 0);
    end

    // Mode changed mid-symbol only affects samples after the next tick.
    symbol_div = 7; mode = 2'b00; bit_drv = 1'b0;
    carrier_a = to_s(256); carrier_b = '0; carrier_valid = 1'b1;
    do_reset();
    for (int c = 0; c < 10; c++) step();
    mode = 2'b11;
    for (int c = 11; c <= 16; c++) begin
      step();
      chk("midmode_hold", mod_sample, 0);
    end
    step();
    chk("midmode_apply", mod_sample, SMIN);

    // Reset mid-operation at cnt = 7, symbol_count = 12.
    symbol_div = 9; mode = 2'b11; bit_drv = 1'b1; carrier_valid = 1'b1;
    do_reset();
    for (int c = 0; c < 127; c++) step();
    chk("mid_count", symbol_count, 12);
    chk("mid_sample", mod_sample, SMAX);
    reset = 1'b1;
    step();
    chk("rst_tick", symbol_tick, 0);
    chk("rst_bit", symbol_bit, 0);
    chk("rst_count", symbol_count, 0);
    chk("rst_sample", mod_sample, 0);
    chk("rst_valid", mod_valid, 0);
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      chk("rst_wait", symbol_tick, 0);
      step();
    end
    chk("rst_first", symbol_tick, 1);

    // Randomized runs against the cycle-indexed model.
    for (int r = 0; r < 3; r++) begin
      run_div = (r == 0) ? 0 : (r == 1) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 9));
      symbol_div = DW'(run_div);
      do_reset();
      exp_s = 0; exp_v = 0;
      for (int c = 0; c < NRAND; c++) begin
        if (c > 0) begin
          exp_v = hv[c - 1];
          if (hv[c - 1] != 0)
            exp_s = model_mod(held_bit(c - 1), held_mode(c - 1), ha[c - 1], hf[c - 1]);
        end
        chk("rnd_tick", symbol_tick, (c > 0 && c % (run_div + 1) == 0) ? 1 : 0);
        chk("rnd_bit", symbol_bit, held_bit(c));
        chk("rnd_count", symbol_count, (c / (run_div + 1)) % 31);
        chk("rnd_valid", mod_valid, exp_v);
        chk("rnd_sample", mod_sample, exp_s);
        hb[c] = int'($urandom_range(0, 1));
        hm[c] = int'($urandom_range(0, 3));
        ha[c] = ($urandom_range(0, 7) == 0) ? SMIN : int'($urandom_range(0, 4095)) - 2048;
        hf[c] = int'($urandom_range(0, 4095)) - 2048;
        hv[c] = ($urandom_range(0, 3) == 0) ? 0 : 1;
        bit_drv = hb[c][0]; mode = hm[c][1:0];
        carrier_a = to_s(ha[c]); carrier_b = to_s(hf[c]); carrier_valid = hv[c][0];
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
